// File: rtl/pe_mv_accumulator.sv
// pe_mv_accumulator
//
// Matrix-vector processing element. Each accepted beat carries one
// LANES x LANES signed matrix tile and one LANES-element signed vector
// slice. The element forms LANES dot products and accumulates them over
// num_tiles tiles, then holds the result on output_data with out_valid
// high until the next start.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse: clear accumulators, load num_tiles, begin job
//   num_tiles    tiles to accumulate, sampled only while start is high
//   in_valid     matrix_data/vector_data carry a tile this cycle
//   matrix_data  element (r,c) at [(r*LANES+c)*DATA_W +: DATA_W]
//   vector_data  element c at [c*DATA_W +: DATA_W]
//   output_data  accumulator r at [r*ACC_W +: ACC_W]
//   out_valid    level, high while output_data holds a finished result
//   done         one-cycle pulse on the first out_valid cycle
//   busy         high while accumulating or draining
//   state_dbg    current FSM state (0 IDLE, 1 ACCUM, 2 DRAIN, 3 DONE)
//
// Handshake: there is no backpressure. A tile is taken on every cycle
// where in_valid is high, the FSM is in ACCUM, start is low and tiles
// remain; in_valid is ignored in every other cycle.

module pe_mv_accumulator #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int TILE_CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [TILE_CNT_W-1:0]           num_tiles,
  input  logic                            in_valid,
  input  logic [LANES*LANES*DATA_W-1:0]   matrix_data,
  input  logic [LANES*DATA_W-1:0]         vector_data,
  output logic [LANES*ACC_W-1:0]          output_data,
  output logic                            out_valid,
  output logic                            done,
  output logic                            busy,
  output logic [1:0]                      state_dbg
);

  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [TILE_CNT_W-1:0]     remaining_q;
  logic signed [PROD_W-1:0]  prod_q [LANES*LANES];
  logic                      s1_valid_q;
  logic signed [ACC_W-1:0]   acc_q [LANES];
  logic signed [ACC_W-1:0]   row_sum [LANES];
  logic                      done_seen_q;
  logic                      capture;

  // A tile is taken only in ACCUM and never in a start cycle.
  assign capture = (state_q == S_ACCUM) && in_valid && !start;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (num_tiles != '0) ? S_ACCUM : S_DONE;
    end else begin
      case (state_q)
        S_ACCUM: if (capture && remaining_q == TILE_CNT_W'(1)) state_d = S_DRAIN;
        // Stage 2 writes the accumulators directly, so once stage 1 is
        // empty the last product has already landed in acc_q.
        S_DRAIN: if (!s1_valid_q) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          remaining_q <= '0;
    else if (start)   remaining_q <= num_tiles;
    else if (capture) remaining_q <= remaining_q - TILE_CNT_W'(1);
  end

  // ---------------- Stage 1: products ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < LANES*LANES; i++) prod_q[i] <= '0;
    end else begin
      // start forces capture low, which also discards any in-flight product.
      s1_valid_q <= capture;
      if (capture) begin
        for (int r = 0; r < LANES; r++) begin
          for (int c = 0; c < LANES; c++) begin
            prod_q[r*LANES+c] <= $signed(matrix_data[(r*LANES+c)*DATA_W +: DATA_W])
                               * $signed(vector_data[c*DATA_W +: DATA_W]);
          end
        end
      end
    end
  end

  // ---------------- Stage 2: row sums into accumulators ----------------
  always_comb begin
    for (int r = 0; r < LANES; r++) begin
      row_sum[r] = '0;
      for (int c = 0; c < LANES; c++) begin
        row_sum[r] = row_sum[r]
                   + {{(ACC_W-PROD_W){prod_q[r*LANES+c][PROD_W-1]}}, prod_q[r*LANES+c]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < LANES; r++) acc_q[r] <= '0;
    end else if (start) begin
      for (int r = 0; r < LANES; r++) acc_q[r] <= '0;
    end else if (s1_valid_q) begin
      // Two's complement wrap, no saturation.
      for (int r = 0; r < LANES; r++) acc_q[r] <= acc_q[r] + row_sum[r];
    end
  end

  // ---------------- Outputs ----------------
  // done_seen_q marks that DONE was already occupied last cycle; a start
  // clears it so a zero-tile restart from DONE pulses done again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        done_seen_q <= 1'b0;
    else if (start) done_seen_q <= 1'b0;
    else            done_seen_q <= (state_q == S_DONE);
  end

  always_comb begin
    output_data = '0;
    for (int r = 0; r < LANES; r++) output_data[r*ACC_W +: ACC_W] = acc_q[r];
  end

  assign out_valid = (state_q == S_DONE);
  assign done      = (state_q == S_DONE) && !done_seen_q;
  assign busy      = (state_q == S_ACCUM) || (state_q == S_DRAIN);
  assign state_dbg = state_q;

endmodule
